// File: rtl/reorder_buffer_if.sv
// Dispatch, completion, operand-lookup and retire signals between the core and its reorder buffer.
// master = dispatch/execute side, slave = the reorder buffer itself.
interface reorder_buffer_if #(
   parameter int ENTRY_LOG2         = 5,
   parameter int NUM_REGISTERS_LOG2 = 5,
   parameter int DATA_W             = 32
);
   logic                          flush;
   logic                          resolve;
   logic                          alloc0;
   logic                          alloc1;
   logic                          alloc_spec0;
   logic                          alloc_spec1;
   logic [NUM_REGISTERS_LOG2-1:0] alloc_reg0;
   logic [NUM_REGISTERS_LOG2-1:0] alloc_reg1;
   logic [ENTRY_LOG2-1:0]         alloc_rob0;
   logic [ENTRY_LOG2-1:0]         alloc_rob1;
   logic                          alloc_ready;
   logic                          cmpl0;
   logic                          cmpl1;
   logic [ENTRY_LOG2-1:0]         cmpl_rob0;
   logic [ENTRY_LOG2-1:0]         cmpl_rob1;
   logic [DATA_W-1:0]             cmpl_data0;
   logic [DATA_W-1:0]             cmpl_data1;
   logic [ENTRY_LOG2-1:0]         rd_rob0;
   logic [ENTRY_LOG2-1:0]         rd_rob1;
   logic                          rd_done0;
   logic                          rd_done1;
   logic [DATA_W-1:0]             rd_data0;
   logic [DATA_W-1:0]             rd_data1;
   logic                          pop0;
   logic                          pop1;
   logic [NUM_REGISTERS_LOG2-1:0] pop_reg0;
   logic [NUM_REGISTERS_LOG2-1:0] pop_reg1;
   logic [ENTRY_LOG2-1:0]         pop_rob0;
   logic [ENTRY_LOG2-1:0]         pop_rob1;
   logic [DATA_W-1:0]             pop_data0;
   logic [DATA_W-1:0]             pop_data1;

   modport master (
      output flush, resolve,
      output alloc0, alloc1, alloc_spec0, alloc_spec1, alloc_reg0, alloc_reg1,
      input  alloc_rob0, alloc_rob1, alloc_ready,
      output cmpl0, cmpl1, cmpl_rob0, cmpl_rob1, cmpl_data0, cmpl_data1,
      output rd_rob0, rd_rob1,
      input  rd_done0, rd_done1, rd_data0, rd_data1,
      input  pop0, pop1, pop_reg0, pop_reg1, pop_rob0, pop_rob1, pop_data0, pop_data1
   );

   modport slave (
      input  flush, resolve,
      input  alloc0, alloc1, alloc_spec0, alloc_spec1, alloc_reg0, alloc_reg1,
      output alloc_rob0, alloc_rob1, alloc_ready,
      input  cmpl0, cmpl1, cmpl_rob0, cmpl_rob1, cmpl_data0, cmpl_data1,
      input  rd_rob0, rd_rob1,
      output rd_done0, rd_done1, rd_data0, rd_data1,
      output pop0, pop1, pop_reg0, pop_reg1, pop_rob0, pop_rob1, pop_data0, pop_data1
   );
endinterface

// File: rtl/reorder_buffer.sv
// Circular 2-wide reorder buffer: allocates at dispatch, collects results from two pipes,
// retires in program order and discards/commits speculative tail entries on flush/resolve.
module reorder_buffer #(
   parameter int NUM_ENTRIES        = 32,
   parameter int ENTRY_LOG2         = 5,
   parameter int NUM_REGISTERS_LOG2 = 5,
   parameter int DATA_W             = 32
) (
   input logic             clk,
   input logic             reset,
   reorder_buffer_if.slave rob_bus
);
   localparam int              CW          = ENTRY_LOG2 + 1;
   localparam logic [CW-1:0]   READY_LIMIT = CW'(NUM_ENTRIES - 2);
   localparam logic [ENTRY_LOG2-1:0] ONE   = ENTRY_LOG2'(1);

   logic [ENTRY_LOG2-1:0]         head;
   logic [ENTRY_LOG2-1:0]         tail;
   logic [CW-1:0]                 count;
   logic [CW-1:0]                 spec_count;
   logic [NUM_ENTRIES-1:0]        vld;
   logic [NUM_ENTRIES-1:0]        done;
   logic [NUM_ENTRIES-1:0]        spec;
   logic [NUM_REGISTERS_LOG2-1:0] entry_reg  [NUM_ENTRIES];
   logic [DATA_W-1:0]             entry_data [NUM_ENTRIES];

   logic [ENTRY_LOG2-1:0]  head_plus1;
   logic [ENTRY_LOG2-1:0]  alloc_idx1;
   logic                   ready;
   logic                   take0;
   logic                   take1;
   logic                   retire0;
   logic                   retire1;
   logic                   cmpl_hit0;
   logic                   cmpl_hit1;
   logic [CW-1:0]          n_alloc;
   logic [CW-1:0]          n_spec_alloc;
   logic [CW-1:0]          n_pop;
   logic [CW-1:0]          n_flush;
   logic [NUM_ENTRIES-1:0] vld_next;
   logic [NUM_ENTRIES-1:0] done_next;
   logic [NUM_ENTRIES-1:0] spec_next;
   logic [ENTRY_LOG2-1:0]  head_next;
   logic [ENTRY_LOG2-1:0]  tail_next;
   logic [CW-1:0]          count_next;
   logic [CW-1:0]          spec_count_next;

   // Dispatch side: two free slots are required even for a single request.
   assign ready      = reset && (count <= READY_LIMIT) && !rob_bus.flush;
   assign take0      = rob_bus.alloc0 && ready;
   assign take1      = rob_bus.alloc1 && ready;
   assign alloc_idx1 = rob_bus.alloc0 ? tail + ONE : tail;

   assign rob_bus.alloc_ready = ready;
   assign rob_bus.alloc_rob0  = tail;
   assign rob_bus.alloc_rob1  = alloc_idx1;

   // Completion only lands on live entries; a stale index is silently dropped.
   assign cmpl_hit0 = rob_bus.cmpl0 && vld[rob_bus.cmpl_rob0];
   assign cmpl_hit1 = rob_bus.cmpl1 && vld[rob_bus.cmpl_rob1];

   assign rob_bus.rd_done0 = vld[rob_bus.rd_rob0] && done[rob_bus.rd_rob0];
   assign rob_bus.rd_done1 = vld[rob_bus.rd_rob1] && done[rob_bus.rd_rob1];
   assign rob_bus.rd_data0 = entry_data[rob_bus.rd_rob0];
   assign rob_bus.rd_data1 = entry_data[rob_bus.rd_rob1];

   // Retire side: the second slot can only go if the first one does.
   assign head_plus1 = head + ONE;
   assign retire0    = reset && (count != '0) && vld[head] && done[head] && !spec[head];
   assign retire1    = retire0 && vld[head_plus1] && done[head_plus1] && !spec[head_plus1];

   assign rob_bus.pop0      = retire0;
   assign rob_bus.pop1      = retire1;
   assign rob_bus.pop_rob0  = head;
   assign rob_bus.pop_rob1  = head_plus1;
   assign rob_bus.pop_reg0  = entry_reg[head];
   assign rob_bus.pop_reg1  = entry_reg[head_plus1];
   assign rob_bus.pop_data0 = entry_data[head];
   assign rob_bus.pop_data1 = entry_data[head_plus1];

   assign n_alloc      = CW'(take0) + CW'(take1);
   assign n_spec_alloc = CW'(take0 && rob_bus.alloc_spec0) + CW'(take1 && rob_bus.alloc_spec1);
   assign n_pop        = CW'(retire0) + CW'(retire1);
   assign n_flush      = rob_bus.flush ? spec_count : '0;

   // Speculative entries sit contiguously at the tail, so a flush is a pure tail rollback.
   assign head_next  = head + ENTRY_LOG2'(n_pop);
   assign tail_next  = tail + ENTRY_LOG2'(n_alloc) - ENTRY_LOG2'(n_flush);
   assign count_next = count + n_alloc - n_pop - n_flush;

   always_comb begin
      if (rob_bus.flush) begin
         spec_count_next = '0;
      end else if (rob_bus.resolve) begin
         spec_count_next = n_spec_alloc;
      end else begin
         spec_count_next = spec_count + n_spec_alloc;
      end
   end

   always_comb begin
      vld_next  = vld;
      done_next = done;
      spec_next = spec;
      if (cmpl_hit0) done_next[rob_bus.cmpl_rob0] = 1'b1;
      if (cmpl_hit1) done_next[rob_bus.cmpl_rob1] = 1'b1;
      if (retire0) vld_next[head] = 1'b0;
      if (retire1) vld_next[head_plus1] = 1'b0;
      if (rob_bus.flush) begin
         vld_next  = vld_next & ~spec;
         spec_next = '0;
      end else if (rob_bus.resolve) begin
         spec_next = '0;
      end
      // New entries never overlap live ones, so allocation simply wins.
      if (take0) begin
         vld_next[tail]  = 1'b1;
         done_next[tail] = 1'b0;
         spec_next[tail] = rob_bus.alloc_spec0;
      end
      if (take1) begin
         vld_next[alloc_idx1]  = 1'b1;
         done_next[alloc_idx1] = 1'b0;
         spec_next[alloc_idx1] = rob_bus.alloc_spec1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         spec_count <= '0;
         vld        <= '0;
         done       <= '0;
         spec       <= '0;
      end else begin
         head       <= head_next;
         tail       <= tail_next;
         count      <= count_next;
         spec_count <= spec_count_next;
         vld        <= vld_next;
         done       <= done_next;
         spec       <= spec_next;
      end
   end

   // Payload storage is qualified by the control bits and needs no reset.
   always_ff @(posedge clk) begin
      if (take0) entry_reg[tail] <= rob_bus.alloc_reg0;
      if (take1) entry_reg[alloc_idx1] <= rob_bus.alloc_reg1;
      if (cmpl_hit0) entry_data[rob_bus.cmpl_rob0] <= rob_bus.cmpl_data0;
      if (cmpl_hit1) entry_data[rob_bus.cmpl_rob1] <= rob_bus.cmpl_data1;
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus randomized traffic checked against a
// program-order queue model of the buffer contents.
module tb_reorder_buffer;
   localparam int N  = 32;
   localparam int AW = 5;
   localparam int RW = 5;
   localparam int DW = 32;

   typedef struct {
      logic [AW-1:0] rob;
      logic [RW-1:0] rg;
      bit            spec;
      bit            done;
      logic [DW-1:0] data;
   } entry_t;

   logic   clk = 1'b0;
   logic   reset;
   int     n_chk  = 0;
   int     n_pass = 0;
   entry_t q[$];
   int     m_tail = 0;

   always #5 clk = ~clk;

   reorder_buffer_if #(.ENTRY_LOG2(AW), .NUM_REGISTERS_LOG2(RW), .DATA_W(DW)) bus ();

   reorder_buffer #(.NUM_ENTRIES(N), .ENTRY_LOG2(AW), .NUM_REGISTERS_LOG2(RW), .DATA_W(DW)) dut (
      .clk(clk),
      .reset(reset),
      .rob_bus(bus)
   );

   // ---------------- reference model (program-order queue of live entries) ----------------
   function automatic int find(logic [AW-1:0] r);
      foreach (q[i]) if (q[i].rob == r) return i;
      return -1;
   endfunction

   function automatic bit ok_at(int i);
      return (q.size() > i) && q[i].done && !q[i].spec;
   endfunction

   function automatic bit exp_pop0();
      return reset && ok_at(0);
   endfunction

   function automatic bit exp_pop1();
      return exp_pop0() && ok_at(1);
   endfunction

   function automatic bit exp_ready();
      return reset && ((N - q.size()) >= 2) && !bus.flush;
   endfunction

   function automatic int n_spec();
      int n = 0;
      foreach (q[i]) if (q[i].spec) n++;
      return n;
   endfunction

   task automatic idle();
      bus.flush = 0;       bus.resolve = 0;
      bus.alloc0 = 0;      bus.alloc1 = 0;
      bus.alloc_spec0 = 0; bus.alloc_spec1 = 0;
      bus.alloc_reg0 = '0; bus.alloc_reg1 = '0;
      bus.cmpl0 = 0;       bus.cmpl1 = 0;
      bus.cmpl_rob0 = '0;  bus.cmpl_rob1 = '0;
      bus.cmpl_data0 = '0; bus.cmpl_data1 = '0;
      bus.rd_rob0 = '0;    bus.rd_rob1 = '0;
   endtask

   // Advance the model by one edge using the inputs currently driven, then move to the next negedge.
   task automatic tick();
      int  np;
      bit  acc;
      int  i;
      if (!reset) begin
         q.delete();
         m_tail = 0;
      end else begin
         np  = int'(exp_pop0()) + int'(exp_pop1());
         acc = exp_ready();
         if (acc && ((bus.alloc0 && !bus.alloc_spec0) || (bus.alloc1 && !bus.alloc_spec1)) && !bus.resolve)
            assert (n_spec() == 0) else $error("illegal stimulus: non-spec alloc behind spec entries");
         if (acc)
            assert (!(bus.alloc0 && bus.alloc_spec0 && bus.alloc1 && !bus.alloc_spec1))
               else $error("illegal stimulus: non-spec alloc younger than spec alloc");
         if (bus.cmpl0) begin
            i = find(bus.cmpl_rob0);
            if (i >= 0) begin q[i].done = 1; q[i].data = bus.cmpl_data0; end
         end
         if (bus.cmpl1) begin
            i = find(bus.cmpl_rob1);
            if (i >= 0) begin q[i].done = 1; q[i].data = bus.cmpl_data1; end
         end
         if (bus.flush) begin
            while (q.size() > 0 && q[q.size()-1].spec) begin
               void'(q.pop_back());
               m_tail = (m_tail + N - 1) % N;
            end
         end else if (bus.resolve) begin
            foreach (q[k]) q[k].spec = 0;
         end
         repeat (np) void'(q.pop_front());
         if (acc && bus.alloc0) begin
            q.push_back('{rob: AW'(m_tail), rg: bus.alloc_reg0, spec: bus.alloc_spec0, done: 0, data: '0});
            m_tail = (m_tail + 1) % N;
         end
         if (acc && bus.alloc1) begin
            q.push_back('{rob: AW'(m_tail), rg: bus.alloc_reg1, spec: bus.alloc_spec1, done: 0, data: '0});
            m_tail = (m_tail + 1) % N;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      idle();
      reset = 0;
      tick();
      reset = 1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle();
      reset = 0;
      tick();
      tick();
      bus.alloc0 = 1; bus.alloc1 = 1;
      #1;
      n_chk++; if (bus.alloc_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.alloc_ready); else n_pass++;
      n_chk++; if ({bus.pop0, bus.pop1} !== 2'b00) $display("FAIL reset_pop: got %b%b want 00", bus.pop0, bus.pop1); else n_pass++;
      tick();
      idle();
      reset = 1;
      #1;
      n_chk++; if (bus.alloc_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", bus.alloc_ready); else n_pass++;
      n_chk++; if (bus.alloc_rob0 !== 5'd0) $display("FAIL release_rob0: got %0d want 0", bus.alloc_rob0); else n_pass++;
      n_chk++; if (bus.rd_done0 !== 1'b0) $display("FAIL release_rd_done: got %b want 0", bus.rd_done0); else n_pass++;
      tick();
   endtask

   task automatic test_basic_pair();
      apply_reset();
      bus.alloc0 = 1; bus.alloc_reg0 = 5'd3;
      bus.alloc1 = 1; bus.alloc_reg1 = 5'd4;
      #1;
      n_chk++; if ({bus.alloc_rob0, bus.alloc_rob1} !== {5'd0, 5'd1}) $display("FAIL basic_alloc_idx: got %0d,%0d want 0,1", bus.alloc_rob0, bus.alloc_rob1); else n_pass++;
      tick();
      idle();
      bus.cmpl0 = 1; bus.cmpl_rob0 = 5'd0; bus.cmpl_data0 = 32'hA;
      bus.cmpl1 = 1; bus.cmpl_rob1 = 5'd1; bus.cmpl_data1 = 32'hB;
      #1;
      n_chk++; if (bus.pop0 !== 1'b0) $display("FAIL basic_no_early_pop: got %b want 0", bus.pop0); else n_pass++;
      tick();
      idle();
      #1;
      n_chk++; if ({bus.pop0, bus.pop_reg0, bus.pop_rob0, bus.pop_data0} !== {1'b1, 5'd3, 5'd0, 32'hA})
         $display("FAIL basic_pop0: got %b/%0d/%0d/%h want 1/3/0/a", bus.pop0, bus.pop_reg0, bus.pop_rob0, bus.pop_data0); else n_pass++;
      n_chk++; if ({bus.pop1, bus.pop_reg1, bus.pop_rob1, bus.pop_data1} !== {1'b1, 5'd4, 5'd1, 32'hB})
         $display("FAIL basic_pop1: got %b/%0d/%0d/%h want 1/4/1/b", bus.pop1, bus.pop_reg1, bus.pop_rob1, bus.pop_data1); else n_pass++;
      tick();
      bus.alloc1 = 1; bus.alloc_reg1 = 5'd7;
      #1;
      n_chk++; if ({bus.pop0, bus.alloc_ready} !== 2'b01) $display("FAIL basic_empty: got pop0=%b ready=%b want 0,1", bus.pop0, bus.alloc_ready); else n_pass++;
      n_chk++; if ({bus.alloc_rob0, bus.alloc_rob1} !== {5'd2, 5'd2}) $display("FAIL basic_slot1_only: got %0d,%0d want 2,2", bus.alloc_rob0, bus.alloc_rob1); else n_pass++;
      tick();
      idle();
      #1;
      n_chk++; if (bus.alloc_rob0 !== 5'd3) $display("FAIL basic_tail_after_single: got %0d want 3", bus.alloc_rob0); else n_pass++;
      tick();
   endtask

   task automatic test_in_order();
      apply_reset();
      bus.alloc0 = 1; bus.alloc1 = 1;
      tick();
      idle();
      bus.cmpl1 = 1; bus.cmpl_rob1 = 5'd1; bus.cmpl_data1 = 32'h22;
      tick();
      idle();
      bus.rd_rob0 = 5'd0; bus.rd_rob1 = 5'd1;
      #1;
      n_chk++; if (bus.pop0 !== 1'b0) $display("FAIL inorder_blocked: got %b want 0", bus.pop0); else n_pass++;
      n_chk++; if ({bus.rd_done0, bus.rd_done1} !== 2'b01) $display("FAIL inorder_rd_done: got %b%b want 01", bus.rd_done0, bus.rd_done1); else n_pass++;
      n_chk++; if (bus.rd_data1 !== 32'h22) $display("FAIL inorder_rd_data: got %h want 22", bus.rd_data1); else n_pass++;
      tick();
      bus.cmpl0 = 1; bus.cmpl_rob0 = 5'd0; bus.cmpl_data0 = 32'h11;
      #1;
      n_chk++; if ({bus.rd_done0, bus.pop0} !== 2'b00) $display("FAIL inorder_no_bypass: got rd_done0=%b pop0=%b want 0,0", bus.rd_done0, bus.pop0); else n_pass++;
      tick();
      idle();
      #1;
      n_chk++; if ({bus.pop0, bus.pop1, bus.pop_data0, bus.pop_data1} !== {2'b11, 32'h11, 32'h22})
         $display("FAIL inorder_pop_both: got %b%b %h %h want 11 11 22", bus.pop0, bus.pop1, bus.pop_data0, bus.pop_data1); else n_pass++;
      tick();
   endtask

   task automatic test_fill_wrap();
      apply_reset();
      for (int k = 0; k < 15; k++) begin
         idle();
         bus.alloc0 = 1; bus.alloc_reg0 = RW'(k);
         bus.alloc1 = 1; bus.alloc_reg1 = RW'(k + 1);
         #1;
         n_chk++; if (bus.alloc_rob0 !== AW'(2 * k)) $display("FAIL fill_idx_%0d: got %0d want %0d", k, bus.alloc_rob0, 2 * k); else n_pass++;
         tick();
      end
      idle();
      bus.alloc0 = 1;
      #1;
      n_chk++; if (bus.alloc_ready !== 1'b1) $display("FAIL fill_ready_at_30: got %b want 1", bus.alloc_ready); else n_pass++;
      tick();
      idle();
      #1;
      n_chk++; if ({bus.alloc_ready, bus.alloc_rob0} !== {1'b0, 5'd31}) $display("FAIL fill_ready_at_31: got %b/%0d want 0/31", bus.alloc_ready, bus.alloc_rob0); else n_pass++;
      for (int k = 0; k < 6; k++) begin
         idle();
         bus.cmpl0 = 1; bus.cmpl_rob0 = AW'(2 * k);     bus.cmpl_data0 = 32'(100 + 2 * k);
         bus.cmpl1 = 1; bus.cmpl_rob1 = AW'(2 * k + 1); bus.cmpl_data1 = 32'(101 + 2 * k);
         #1;
         if (k > 0) begin
            n_chk++; if ({bus.pop0, bus.pop1, bus.pop_rob0} !== {2'b11, AW'(2 * k - 2)})
               $display("FAIL fill_retire_%0d: got %b%b rob %0d want 11 rob %0d", k, bus.pop0, bus.pop1, bus.pop_rob0, 2 * k - 2); else n_pass++;
         end
         tick();
      end
      idle();
      #1;
      n_chk++; if ({bus.pop0, bus.pop1, bus.pop_rob0} !== {2'b11, 5'd10}) $display("FAIL fill_retire_last: got %b%b rob %0d want 11 rob 10", bus.pop0, bus.pop1, bus.pop_rob0); else n_pass++;
      tick();
      for (int j = 0; j < 5; j++) begin
         idle();
         bus.alloc0 = 1; bus.alloc1 = 1;
         #1;
         n_chk++; if ({bus.alloc_rob0, bus.alloc_rob1} !== {AW'(31 + 2 * j), AW'(2 * j)})
            $display("FAIL wrap_idx_%0d: got %0d,%0d want %0d,%0d", j, bus.alloc_rob0, bus.alloc_rob1, (31 + 2 * j) % N, 2 * j); else n_pass++;
         tick();
      end
      idle();
      bus.cmpl0 = 1; bus.cmpl_rob0 = 5'd31; bus.cmpl_data0 = 32'hCAFE;
      bus.cmpl1 = 1; bus.cmpl_rob1 = 5'd0;  bus.cmpl_data1 = 32'hBEEF;
      tick();
      idle();
      bus.rd_rob0 = 5'd31; bus.rd_rob1 = 5'd12;
      #1;
      n_chk++; if ({bus.rd_done0, bus.rd_data0} !== {1'b1, 32'hCAFE}) $display("FAIL wrap_rd31: got %b/%h want 1/cafe", bus.rd_done0, bus.rd_data0); else n_pass++;
      n_chk++; if ({bus.rd_done1, bus.pop0, bus.alloc_ready} !== 3'b001) $display("FAIL wrap_head_wait: got %b%b%b want 001", bus.rd_done1, bus.pop0, bus.alloc_ready); else n_pass++;
      tick();
   endtask

   task automatic test_flush();
      apply_reset();
      bus.alloc0 = 1; bus.alloc1 = 1;
      tick();
      bus.alloc_spec0 = 1; bus.alloc_spec1 = 1;
      tick();
      bus.alloc1 = 0; bus.alloc_spec1 = 0;
      tick();
      idle();
      bus.cmpl0 = 1; bus.cmpl_rob0 = 5'd3; bus.cmpl_data0 = 32'h33;
      bus.cmpl1 = 1; bus.cmpl_rob1 = 5'd0; bus.cmpl_data1 = 32'h50;
      tick();
      idle();
      bus.flush = 1; bus.alloc0 = 1; bus.rd_rob0 = 5'd3;
      #1;
      n_chk++; if ({bus.alloc_ready, bus.rd_done0} !== 2'b01) $display("FAIL flush_cycle: got ready=%b rd_done3=%b want 0,1", bus.alloc_ready, bus.rd_done0); else n_pass++;
      n_chk++; if ({bus.pop0, bus.pop1, bus.pop_rob0} !== {2'b10, 5'd0}) $display("FAIL flush_retire: got %b%b rob %0d want 10 rob 0", bus.pop0, bus.pop1, bus.pop_rob0); else n_pass++;
      tick();
      idle();
      bus.rd_rob0 = 5'd3;
      #1;
      n_chk++; if ({bus.alloc_ready, bus.alloc_rob0, bus.rd_done0} !== {1'b1, 5'd2, 1'b0})
         $display("FAIL flush_rollback: got ready=%b rob0=%0d rd_done3=%b want 1,2,0", bus.alloc_ready, bus.alloc_rob0, bus.rd_done0); else n_pass++;
      tick();
   endtask

   task automatic test_resolve();
      apply_reset();
      bus.alloc0 = 1; bus.alloc1 = 1; bus.alloc_spec0 = 1; bus.alloc_spec1 = 1;
      tick();
      idle();
      bus.cmpl0 = 1; bus.cmpl_rob0 = 5'd0; bus.cmpl_data0 = 32'h70;
      bus.cmpl1 = 1; bus.cmpl_rob1 = 5'd1; bus.cmpl_data1 = 32'h71;
      tick();
      idle();
      #1;
      n_chk++; if (bus.pop0 !== 1'b0) $display("FAIL resolve_spec_held: got %b want 0", bus.pop0); else n_pass++;
      tick();
      bus.resolve = 1;
      #1;
      n_chk++; if (bus.pop0 !== 1'b0) $display("FAIL resolve_same_cycle: got %b want 0", bus.pop0); else n_pass++;
      tick();
      idle();
      #1;
      n_chk++; if ({bus.pop0, bus.pop1, bus.pop_rob1, bus.pop_data1} !== {2'b11, 5'd1, 32'h71})
         $display("FAIL resolve_retire: got %b%b rob %0d %h want 11 rob 1 71", bus.pop0, bus.pop1, bus.pop_rob1, bus.pop_data1); else n_pass++;
      tick();
   endtask

   task automatic test_reset_midstream();
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         bus.alloc0 = 1; bus.alloc1 = 1;
         tick();
      end
      idle();
      bus.cmpl0 = 1; bus.cmpl_rob0 = 5'd0; bus.cmpl1 = 1; bus.cmpl_rob1 = 5'd1;
      tick();
      idle();
      reset = 0;
      bus.alloc0 = 1;
      #1;
      n_chk++; if ({bus.pop0, bus.pop1, bus.alloc_ready} !== 3'b000) $display("FAIL midreset_outputs: got %b%b%b want 000", bus.pop0, bus.pop1, bus.alloc_ready); else n_pass++;
      tick();
      idle();
      reset = 1;
      bus.rd_rob0 = 5'd0;
      #1;
      n_chk++; if ({bus.alloc_rob0, bus.alloc_ready, bus.pop0, bus.rd_done0} !== {5'd0, 3'b100})
         $display("FAIL midreset_release: got rob0=%0d ready=%b pop0=%b rd_done=%b want 0,1,0,0", bus.alloc_rob0, bus.alloc_ready, bus.pop0, bus.rd_done0); else n_pass++;
      tick();
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 1500; c++) begin
         int sp;
         int sz;
         int i0;
         int i1;
         int fi;
         bit ed;
         sp = n_spec();
         sz = q.size();
         idle();
         if ($urandom_range(0, 15) == 0) bus.flush = 1;
         else if (sp > 0 && $urandom_range(0, 7) == 0) bus.resolve = 1;
         bus.alloc0 = ($urandom_range(0, 1) == 1);
         bus.alloc1 = ($urandom_range(0, 1) == 1);
         bus.alloc_reg0 = RW'($urandom);
         bus.alloc_reg1 = RW'($urandom);
         bus.alloc_spec0 = (sp > 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
         bus.alloc_spec1 = bus.alloc_spec0 ? 1'b1 : ($urandom_range(0, 3) == 0);
         if (sz > 0 && $urandom_range(0, 3) != 0) begin
            i0 = $urandom_range(0, (sz > 6) ? 5 : sz - 1);
            bus.cmpl0 = 1; bus.cmpl_rob0 = q[i0].rob; bus.cmpl_data0 = $urandom;
         end else begin
            bus.cmpl0 = ($urandom_range(0, 3) == 0); bus.cmpl_rob0 = AW'($urandom); bus.cmpl_data0 = $urandom;
         end
         if (sz > 1 && $urandom_range(0, 3) != 0) begin
            i1 = $urandom_range(0, (sz > 6) ? 5 : sz - 1);
            bus.cmpl1 = 1; bus.cmpl_rob1 = q[i1].rob; bus.cmpl_data1 = $urandom;
         end else begin
            bus.cmpl1 = ($urandom_range(0, 3) == 0); bus.cmpl_rob1 = AW'($urandom); bus.cmpl_data1 = $urandom;
         end
         if (bus.cmpl0 && bus.cmpl1 && bus.cmpl_rob0 == bus.cmpl_rob1) bus.cmpl1 = 0;
         bus.rd_rob0 = (sz > 0) ? q[$urandom_range(0, sz - 1)].rob : AW'($urandom);
         bus.rd_rob1 = AW'($urandom);
         #1;
         n_chk++; if (bus.alloc_ready !== exp_ready()) $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.alloc_ready, exp_ready()); else n_pass++;
         n_chk++; if ({bus.alloc_rob0, bus.alloc_rob1} !== {AW'(m_tail), AW'(bus.alloc0 ? m_tail + 1 : m_tail)})
            $display("FAIL rnd_alloc_idx c%0d: got %0d,%0d want tail %0d", c, bus.alloc_rob0, bus.alloc_rob1, m_tail); else n_pass++;
         n_chk++; if ({bus.pop0, bus.pop1} !== {exp_pop0(), exp_pop1()}) $display("FAIL rnd_pop c%0d: got %b%b want %b%b", c, bus.pop0, bus.pop1, exp_pop0(), exp_pop1()); else n_pass++;
         if (exp_pop0()) begin
            n_chk++; if ({bus.pop_rob0, bus.pop_reg0, bus.pop_data0} !== {q[0].rob, q[0].rg, q[0].data})
               $display("FAIL rnd_pop0_fields c%0d: got %0d/%0d/%h want %0d/%0d/%h", c, bus.pop_rob0, bus.pop_reg0, bus.pop_data0, q[0].rob, q[0].rg, q[0].data); else n_pass++;
         end
         if (exp_pop1()) begin
            n_chk++; if ({bus.pop_rob1, bus.pop_reg1, bus.pop_data1} !== {q[1].rob, q[1].rg, q[1].data})
               $display("FAIL rnd_pop1_fields c%0d: got %0d/%0d/%h want %0d/%0d/%h", c, bus.pop_rob1, bus.pop_reg1, bus.pop_data1, q[1].rob, q[1].rg, q[1].data); else n_pass++;
         end
         fi = find(bus.rd_rob0);
         ed = (fi >= 0) && q[fi].done;
         n_chk++; if (bus.rd_done0 !== ed) $display("FAIL rnd_rd_done0 c%0d: got %b want %b", c, bus.rd_done0, ed); else n_pass++;
         if (ed) begin
            n_chk++; if (bus.rd_data0 !== q[fi].data) $display("FAIL rnd_rd_data0 c%0d: got %h want %h", c, bus.rd_data0, q[fi].data); else n_pass++;
         end
         fi = find(bus.rd_rob1);
         ed = (fi >= 0) && q[fi].done;
         n_chk++; if (bus.rd_done1 !== ed) $display("FAIL rnd_rd_done1 c%0d: got %b want %b", c, bus.rd_done1, ed); else n_pass++;
         tick();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 0;
      idle();
      test_reset();
      test_basic_pair();
      test_in_order();
      test_fill_wrap();
      test_flush();
      test_resolve();
      test_reset_midstream();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
